// File: rtl/rv_ctrl_pkg.sv
// rtl/rv_ctrl_pkg.sv - shared state, opcode and select encodings for the multi-cycle RV64 core
package rv_ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_e;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    localparam logic [1:0] SRC_A_PC     = 2'b00;
    localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
    localparam logic [1:0] SRC_A_RS1    = 2'b10;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_FOUR = 2'b01;
    localparam logic [1:0] SRC_B_IMM  = 2'b10;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic PC_SRC_ALU    = 1'b0;
    localparam logic PC_SRC_ALUOUT = 1'b1;
    localparam logic IORD_PC       = 1'b0;
    localparam logic IORD_ALUOUT   = 1'b1;

    function automatic logic is_legal(input logic [31:0] instr);
        logic ok;
        case (instr[6:0])
            OP_RTYPE, OP_IMM, OP_LOAD, OP_STORE: ok = 1'b1;
            OP_BRANCH: ok = (instr[14:12] == F3_BEQ) || (instr[14:12] == F3_BNE);
            default:   ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - memory wait counter with timeout compare
module mem_wait_timer #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The wait that would be the TIMEOUT_CYCLES-th one expires; a ready in that cycle still completes.
    assign expired = en && (cnt_q == LIMIT);

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - main control FSM of the multi-cycle RV64 core
module multicycle_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8,
    parameter int RET_W          = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      instr,
    input  logic             alu_zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             illegal,
    output logic             bus_err,
    output logic [RET_W-1:0] retired
);

    state_e           state_q, state_d;
    logic             illegal_q, illegal_d;
    logic             bus_err_q, bus_err_d;
    logic [RET_W-1:0] retired_q, retired_d;
    logic             wait_en;
    logic             timeout;
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic             unused_instr_bits;

    assign opcode            = instr[6:0];
    assign funct3            = instr[14:12];
    assign unused_instr_bits = ^{instr[31:15], instr[11:7]};
    assign wait_en           = mem_req && !mem_ready;

    mem_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_W         (CNT_W)
    ) u_wait_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (!wait_en),
        .en     (wait_en),
        .expired(timeout)
    );

    always_comb begin
        state_d    = state_q;
        illegal_d  = illegal_q;
        bus_err_d  = bus_err_q;
        retired_d  = retired_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = IORD_PC;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PC_SRC_ALU;
        alu_src_a  = SRC_A_PC;
        alu_src_b  = SRC_B_RS2;
        alu_op     = ALU_ADD;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = SRC_B_FOUR;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (timeout) begin
                    bus_err_d = 1'b1;
                    state_d   = S_TRAP;
                end
            end
            S_DECODE: begin
                // Branch target is precomputed into ALUOut while the opcode is dispatched.
                alu_src_a = SRC_A_OLD_PC;
                alu_src_b = SRC_B_IMM;
                if (is_legal(instr)) begin
                    state_d = S_EXEC;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = S_TRAP;
                end
            end
            S_EXEC: begin
                alu_src_a = SRC_A_RS1;
                case (opcode)
                    OP_RTYPE: begin
                        alu_src_b = SRC_B_RS2;
                        alu_op    = ALU_FUNCT;
                        state_d   = S_WB;
                    end
                    OP_IMM: begin
                        alu_src_b = SRC_B_IMM;
                        alu_op    = ALU_FUNCT;
                        state_d   = S_WB;
                    end
                    OP_LOAD, OP_STORE: begin
                        alu_src_b = SRC_B_IMM;
                        state_d   = S_MEM;
                    end
                    OP_BRANCH: begin
                        alu_src_b = SRC_B_RS2;
                        alu_op    = ALU_SUB;
                        pc_src    = PC_SRC_ALUOUT;
                        pc_write  = alu_zero ^ funct3[0];
                        retired_d = retired_q + RET_W'(1);
                        state_d   = S_FETCH;
                    end
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = S_TRAP;
                    end
                endcase
            end
            S_MEM: begin
                mem_req = 1'b1;
                iord    = IORD_ALUOUT;
                mem_we  = (opcode == OP_STORE);
                if (mem_ready) begin
                    if (opcode == OP_STORE) begin
                        retired_d = retired_q + RET_W'(1);
                        state_d   = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (timeout) begin
                    bus_err_d = 1'b1;
                    state_d   = S_TRAP;
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = (opcode == OP_LOAD);
                retired_d  = retired_q + RET_W'(1);
                state_d    = S_FETCH;
            end
            default: begin
                state_d = S_TRAP;
            end
        endcase

        // Reset silences every enable at once, even mid-transaction.
        if (!rst_n) begin
            mem_req    = 1'b0;
            mem_we     = 1'b0;
            iord       = IORD_PC;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            pc_src     = PC_SRC_ALU;
            alu_src_a  = SRC_A_PC;
            alu_src_b  = SRC_B_RS2;
            alu_op     = ALU_ADD;
            reg_write  = 1'b0;
            mem_to_reg = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
            retired_q <= retired_d;
        end
    end

    assign illegal = illegal_q;
    assign bus_err = bus_err_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = 32'h0;
    logic        alu_zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_we, iord, ir_write, pc_write, pc_src;
    logic [1:0]  alu_src_a, alu_src_b, alu_op;
    logic        reg_write, mem_to_reg, illegal, bus_err;
    logic [31:0] retired;
    logic [15:0] ctl;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_ret = 32'h0;

    localparam logic [31:0] ADDI = 32'h00500093;
    localparam logic [31:0] LD   = 32'h0000B083;
    localparam logic [31:0] SD   = 32'h00113023;
    localparam logic [31:0] BEQ  = 32'h00208063;
    localparam logic [31:0] BNE  = 32'h00209063;

    multicycle_ctrl #(
        .TIMEOUT_CYCLES(4),
        .CNT_W         (8),
        .RET_W         (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .instr     (instr),
        .alu_zero  (alu_zero),
        .mem_ready (mem_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .iord      (iord),
        .ir_write  (ir_write),
        .pc_write  (pc_write),
        .pc_src    (pc_src),
        .alu_src_a (alu_src_a),
        .alu_src_b (alu_src_b),
        .alu_op    (alu_op),
        .reg_write (reg_write),
        .mem_to_reg(mem_to_reg),
        .illegal   (illegal),
        .bus_err   (bus_err),
        .retired   (retired)
    );

    always #5 clk = ~clk;

    assign ctl = {mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a,
                  alu_src_b, alu_op, reg_write, mem_to_reg, illegal, bus_err};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n     = 1'b0;
        mem_ready = 1'b0;
        #1;
        check("reset_ctl", {16'h0, ctl}, 32'h0);
        check("reset_retired", retired, 32'h0);
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        exp_ret = 32'h0;
    endtask

    // Drives one instruction from its first FETCH cycle; memory answers after wf/wm wait cycles.
    task automatic run_instr(input logic [31:0] ins, input int wf, input int wm, input logic z);
        logic [6:0]  op;
        logic        is_ld, is_st, is_br, is_alu, is_mem, taken, last_pcsrc, last_rw;
        int          n, nreq, fcnt, mcnt, creq, cwe, cm2r, cpcw, cirw, cbad;
        logic [31:0] r0, rlast;
        op     = ins[6:0];
        is_ld  = (op == 7'b0000011);
        is_st  = (op == 7'b0100011);
        is_br  = (op == 7'b1100011);
        is_alu = (op == 7'b0110011) || (op == 7'b0010011);
        is_mem = is_ld || is_st;
        taken  = is_br && (z ^ ins[12]);
        n      = (is_br ? 3 : (is_ld ? 5 : 4)) + wf + (is_mem ? wm : 0);
        nreq   = wf + 1 + (is_mem ? wm + 1 : 0);
        r0     = exp_ret;
        instr  = ins;
        alu_zero = z;
        fcnt = 0; mcnt = 0; creq = 0; cwe = 0; cm2r = 0; cpcw = 0; cirw = 0; cbad = 0;
        rlast = 32'h0; last_pcsrc = 1'b0; last_rw = 1'b0;
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            mem_ready = 1'b0;
            if (mem_req) begin
                if (!iord) begin
                    fcnt++;
                    mem_ready = (fcnt > wf);
                end else begin
                    mcnt++;
                    mem_ready = (mcnt > wm);
                end
            end
            #1;
            creq += int'(mem_req);
            cwe  += int'(mem_we);
            cm2r += int'(reg_write && mem_to_reg);
            cpcw += int'(pc_write);
            cirw += int'(ir_write);
            cbad += int'((mem_we && !mem_req) || (ir_write && (!mem_req || iord)) || illegal || bus_err);
            if (c == n) begin
                rlast      = retired;
                last_pcsrc = pc_src;
                last_rw    = reg_write;
            end
        end
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        exp_ret   = r0 + 32'd1;
        check("retired_before_end", rlast, r0);
        check("retired_after", retired, exp_ret);
        check("mem_req_cycles", creq, nreq);
        check("mem_we_cycles", cwe, is_st ? wm + 1 : 0);
        check("reg_write_last", {31'h0, last_rw}, {31'h0, is_alu || is_ld});
        check("mem_to_reg_cycles", cm2r, is_ld ? 1 : 0);
        check("pc_write_cycles", cpcw, taken ? 2 : 1);
        check("ir_write_cycles", cirw, 1);
        check("gating_violations", cbad, 0);
        check("next_fetch", {30'h0, mem_req, iord}, 32'h2);
        if (is_br) check("branch_pc_src", {31'h0, last_pcsrc}, 32'h1);
    endtask

    task automatic run_trap(input logic [31:0] ins);
        int          creq, cill, cbus;
        logic [31:0] r0;
        r0 = exp_ret; creq = 0; cill = 0; cbus = 0;
        instr = ins;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            mem_ready = mem_req;
            #1;
            if (c == 2) check("illegal_before_decode_end", {31'h0, illegal}, 32'h0);
            if (c >= 3) begin
                creq += int'(mem_req);
                cill += int'(illegal);
                cbus += int'(bus_err);
            end
        end
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        check("trap_illegal_cycles", cill, 6);
        check("trap_bus_err_cycles", cbus, 0);
        check("trap_mem_req_cycles", creq, 0);
        check("trap_retired", retired, r0);
    endtask

    task automatic run_timeout();
        int creq;
        creq  = 0;
        instr = ADDI;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            mem_ready = 1'b0;
            #1;
            if (c == 4) check("timeout_c4", {30'h0, mem_req, bus_err}, 32'h2);
            if (c == 5) check("timeout_c5", {30'h0, mem_req, bus_err}, 32'h1);
            if (c >= 5) creq += int'(mem_req);
        end
        check("timeout_mem_req_after", creq, 0);
        check("timeout_illegal", {31'h0, illegal}, 32'h0);
        check("timeout_retired", retired, 32'h0);
    endtask

    task automatic reset_mid_store();
        instr = SD;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            mem_ready = (c == 1) ? mem_req : 1'b0;
            #1;
        end
        check("sd_mem_phase", {29'h0, mem_req, mem_we, iord}, 32'h7);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset_ctl", {16'h0, ctl}, 32'h0);
        check("async_reset_retired", retired, 32'h0);
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        exp_ret = 32'h0;
        run_instr(ADDI, 0, 0, 1'b0);
    endtask

    initial begin
        logic [31:0] rnd;
        logic [6:0]  op;
        logic [2:0]  f3;
        int          cls;

        reset_dut();
        run_instr(ADDI, 0, 0, 1'b0);
        run_instr(LD, 3, 3, 1'b0);
        run_instr(BEQ, 0, 0, 1'b1);
        run_instr(BEQ, 0, 0, 1'b0);
        run_instr(BNE, 0, 0, 1'b1);
        run_instr(BNE, 0, 0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            cls = $urandom_range(0, 5);
            rnd = $urandom;
            f3  = rnd[14:12];
            case (cls)
                0: op = 7'b0110011;
                1: op = 7'b0010011;
                2: op = 7'b0000011;
                3: op = 7'b0100011;
                4: begin op = 7'b1100011; f3 = 3'b000; end
                default: begin op = 7'b1100011; f3 = 3'b001; end
            endcase
            run_instr({rnd[31:15], f3, rnd[11:7], op}, $urandom_range(0, 3),
                      $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        run_trap(32'h0000007F);

        reset_dut();
        run_instr(ADDI, 0, 0, 1'b0);
        run_trap(32'h0020C063);

        reset_dut();
        run_timeout();

        reset_dut();
        run_instr(ADDI, 1, 0, 1'b0);
        run_instr(SD, 0, 2, 1'b0);
        reset_mid_store();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
